// File: rtl/td4_core_p.sv
// td4_core_p: parametrised TD4 core with carry flag, jumps, IN/OUT ports, step enable and halt detection.
// The program ROM is combinational from pc_out; one instruction retires on every enabled rising edge.
module td4_core_p #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int OPC_REV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] io_input,
  output logic [DATA_W-1:0] regA_o,
  output logic [DATA_W-1:0] regB_o,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] regOut,
  output logic              carry,
  output logic              halted
);

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  logic [3:0] op;

  // Board ROMs store the opcode LSB-first; flip it back to canonical order here.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      if (OPC_REV != 0) begin : g_rev
        assign op[gi] = opcode[3-gi];
      end else begin : g_fwd
        assign op[gi] = opcode[gi];
      end
    end
  endgenerate

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              carry_reg;
  logic              halted_reg;

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic              wr_a;
  logic              wr_b;
  logic              wr_out;
  logic              take_jump;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    src       = '0;
    addend    = '0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_out    = 1'b0;
    take_jump = 1'b0;
    case (op)
      OP_ADD_A:  begin src = a_reg;     addend = immediate; wr_a = 1'b1; end
      OP_MOV_AB: begin src = b_reg;     wr_a = 1'b1; end
      OP_IN_A:   begin src = io_input;  wr_a = 1'b1; end
      OP_MOV_AI: begin src = immediate; wr_a = 1'b1; end
      OP_MOV_BA: begin src = a_reg;     wr_b = 1'b1; end
      OP_ADD_B:  begin src = b_reg;     addend = immediate; wr_b = 1'b1; end
      OP_IN_B:   begin src = io_input;  wr_b = 1'b1; end
      OP_MOV_BI: begin src = immediate; wr_b = 1'b1; end
      OP_OUT_B:  begin src = b_reg;     wr_out = 1'b1; end
      OP_OUT_IM: begin src = immediate; wr_out = 1'b1; end
      OP_JNC:    take_jump = ~carry_reg;
      OP_JMP:    take_jump = 1'b1;
      default:   ;
    endcase
  end

  // Non-ADD ops have a zero addend, so the carry-out is naturally 0 for them.
  assign sum     = {1'b0, src} + {1'b0, addend};
  assign target  = immediate[ADDR_W-1:0];
  assign pc_next = take_jump ? target : pc_reg + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      out_reg    <= '0;
      pc_reg     <= '0;
      carry_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else if (en) begin
      if (wr_a)   a_reg   <= sum[DATA_W-1:0];
      if (wr_b)   b_reg   <= sum[DATA_W-1:0];
      if (wr_out) out_reg <= sum[DATA_W-1:0];
      carry_reg <= sum[DATA_W];
      pc_reg    <= pc_next;
      if (take_jump && (target == pc_reg)) halted_reg <= 1'b1;
    end
  end

  assign regA_o = a_reg;
  assign regB_o = b_reg;
  assign regOut = out_reg;
  assign pc_out = pc_reg;
  assign carry  = carry_reg;
  assign halted = halted_reg;

endmodule

// File: tb/tb_td4_core_p.sv
// Bench for td4_core_p: three configurations (4-bit reversed, 4-bit canonical, 8-bit reversed)
// run directed programs from bench ROMs and are checked against an ISA-level model every cycle.
module tb_td4_core_p;

  typedef struct {
    int a;
    int b;
    int pc;
    int out;
    int c;
    int h;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] io = 8'h00;

  // Programs are stored with canonical opcodes; each DUT sees them in its own bit order.
  logic [3:0] rop [3][16];
  logic [7:0] rim [3][16];
  st_t m [3];
  int dw [3] = '{4, 4, 8};

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] opc0, opc1, opc2;
  logic [3:0] a0, b0, o0, pc0, a1, b1, o1, pc1, pc2;
  logic [7:0] a2, b2, o2;
  logic c0, h0, c1, h1, c2, h2;

  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input logic [3:0] c, input bit rev);
    return rev ? {c[0], c[1], c[2], c[3]} : c;
  endfunction

  assign opc0 = enc(rop[0][pc0], 1'b1);
  assign opc1 = enc(rop[1][pc1], 1'b0);
  assign opc2 = enc(rop[2][pc2], 1'b1);

  td4_core_p #(.DATA_W(4), .ADDR_W(4), .OPC_REV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opc0), .immediate(rim[0][pc0][3:0]),
    .io_input(io[3:0]), .regA_o(a0), .regB_o(b0), .pc_out(pc0), .regOut(o0),
    .carry(c0), .halted(h0));

  td4_core_p #(.DATA_W(4), .ADDR_W(4), .OPC_REV(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opc1), .immediate(rim[1][pc1][3:0]),
    .io_input(io[3:0]), .regA_o(a1), .regB_o(b1), .pc_out(pc1), .regOut(o1),
    .carry(c1), .halted(h1));

  td4_core_p #(.DATA_W(8), .ADDR_W(4), .OPC_REV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opc2), .immediate(rim[2][pc2]),
    .io_input(io), .regA_o(a2), .regB_o(b2), .pc_out(pc2), .regOut(o2),
    .carry(c2), .halted(h2));

  // ISA-level model: one instruction of the table applied to an architectural state.
  function automatic st_t step(st_t s, int op, int im_raw, int io_raw, int w);
    st_t n;
    int mask, im, iv, sum;
    mask = (1 << w) - 1;
    im = im_raw & mask;
    iv = io_raw & mask;
    n = s;
    n.c = 0;
    n.pc = (s.pc + 1) % 16;
    sum = 0;
    case (op)
      0:  begin sum = s.a + im; n.a = sum & mask; n.c = (sum > mask) ? 1 : 0; end
      1:  n.a = s.b;
      2:  n.a = iv;
      3:  n.a = im;
      4:  n.b = s.a;
      5:  begin sum = s.b + im; n.b = sum & mask; n.c = (sum > mask) ? 1 : 0; end
      6:  n.b = iv;
      7:  n.b = im;
      9:  n.out = s.b;
      11: n.out = im;
      14: if (s.c == 0) n.pc = im % 16;
      15: n.pc = im % 16;
      default: ;
    endcase
    if ((op == 15 || (op == 14 && s.c == 0)) && (im % 16) == s.pc) n.h = 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) m[k] <= '{0, 0, 0, 0, 0, 0};
      else if (en) m[k] <= step(m[k], int'(rop[k][m[k].pc]), int'(rim[k][m[k].pc]), int'(io), dw[k]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input int a, input int b, input int pc, input int o,
                     input int c, input int h);
    chk($sformatf("dut%0d.regA", k), a, m[k].a);
    chk($sformatf("dut%0d.regB", k), b, m[k].b);
    chk($sformatf("dut%0d.pc", k), pc, m[k].pc);
    chk($sformatf("dut%0d.regOut", k), o, m[k].out);
    chk($sformatf("dut%0d.carry", k), c, m[k].c);
    chk($sformatf("dut%0d.halted", k), h, m[k].h);
  endtask

  always @(negedge clk) begin
    cmp(0, a0, b0, pc0, o0, c0, h0);
    cmp(1, a1, b1, pc1, o1, c1, h1);
    cmp(2, a2, b2, pc2, o2, c2, h2);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic begin_test(input string name);
    tick();
    rst_n = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        rop[k][i] = 4'b1000;
        rim[k][i] = 8'h00;
      end
    $display("test: %s", name);
  endtask

  task automatic run();
    tick();
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic prog(input int k, input int addr, input logic [3:0] op, input logic [7:0] im);
    rop[k][addr] = op;
    rim[k][addr] = im;
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        rop[k][i] = 4'b1000;
        rim[k][i] = 8'h00;
      end

    begin_test("reset and hold with en=0");
    for (int i = 0; i < 16; i++) prog(0, i, 4'b0000, 8'h05);
    tick();
    rst_n = 1'b1;
    tick(5);
    chk("hold.pc", pc0, 0);
    chk("hold.regA", a0, 0);

    begin_test("ADD carry, JNC not taken");
    prog(0, 0, 4'b0011, 8'h0E);
    prog(0, 1, 4'b0000, 8'h03);
    prog(0, 2, 4'b1110, 8'h08);
    run();
    tick(2);
    chk("add.regA", a0, 1);
    chk("add.carry", c0, 1);
    tick();
    chk("jnc_nt.pc", pc0, 3);
    chk("jnc_nt.carry", c0, 0);

    begin_test("JNC taken");
    prog(0, 0, 4'b0000, 8'h01);
    prog(0, 1, 4'b1110, 8'h06);
    run();
    tick(2);
    chk("jnc_t.pc", pc0, 6);

    begin_test("IN/OUT");
    io = 8'h0A;
    prog(0, 0, 4'b0110, 8'h00);
    prog(0, 1, 4'b1001, 8'h00);
    prog(0, 2, 4'b1011, 8'h05);
    run();
    tick(2);
    chk("out_b.regOut", o0, 4'hA);
    tick();
    chk("out_im.regOut", o0, 4'h5);
    io = 8'h00;

    begin_test("opcode order and 8-bit width");
    prog(0, 0, 4'b0111, 8'h09);
    prog(1, 0, 4'b1110, 8'h09);
    prog(2, 0, 4'b0011, 8'hFF);
    prog(2, 1, 4'b0000, 8'h01);
    run();
    tick();
    chk("rev.regB", b0, 9);
    chk("canon.pc", pc1, 9);
    tick();
    chk("w8.regA", a2, 0);
    chk("w8.carry", c2, 1);

    begin_test("PC wrap");
    run();
    tick(15);
    chk("wrap.pc15", pc0, 15);
    tick();
    chk("wrap.pc0", pc0, 0);
    chk("wrap.halted", h0, 0);

    begin_test("halt and async reset");
    prog(0, 0, 4'b0011, 8'h07);
    prog(0, 1, 4'b1011, 8'h05);
    prog(0, 3, 4'b1111, 8'h03);
    run();
    tick(3);
    chk("pre_halt.halted", h0, 0);
    tick();
    chk("halt.halted", h0, 1);
    chk("halt.pc", pc0, 3);
    tick();
    chk("halt_hold.pc", pc0, 3);
    chk("halt_hold.regA", a0, 7);
    chk("halt_hold.regOut", o0, 5);
    rst_n = 1'b0;
    #1;
    chk("async.regA", a0, 0);
    chk("async.regOut", o0, 0);
    chk("async.pc", pc0, 0);
    chk("async.halted", h0, 0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
